dac_multi_chan_datapath: RTL
============================

Name: dac_multi_chan_datapath

Overview:
- Parametrised successor of the fixed two-channel, four-sample DAC core datapath; runs entirely in the DAC clock domain.
- Takes a packed DMA beat and drives a packed DAC sample bus for NUM_CHANNELS channels, each carrying SAMPLES_PER_CHANNEL samples per clock.
- Each channel has a selectable source (DMA, ramp, constant, zero), an enable and a format conversion.
- Adds a start/sync state machine, a DMA handshake, and underflow detection with a sticky flag and a saturating counter.
- Control inputs are already synchronised into dac_clk by the up_* common/channel register blocks.

Parameters:
- NUM_CHANNELS, 2, number of DAC channels (1..8)
- SAMPLES_PER_CHANNEL, 4, samples per channel per clock (1..8)
- DATA_WIDTH, 16, bits per sample (8..16)

Ports:
- dac_clk  in  1  DAC-side clock
- dac_rst  in  1  asynchronous, active-high reset
- dac_start  in  1  level; 1 = enable datapath, 0 = force IDLE
- dac_sync  in  1  single-cycle alignment pulse
- dac_enable  in  NUM_CHANNELS  per-channel enable
- dac_src_sel  in  2*NUM_CHANNELS  per-channel source: 0 DMA, 1 ramp, 2 constant, 3 zero
- dac_datafmt  in  1  1 = invert MSB of every output sample (offset binary)
- dac_pattern  in  DATA_WIDTH  constant-source value, shared by all channels
- dac_unf_clr  in  1  pulse; clears sticky flag and counter
- dma_valid  in  1  DMA beat valid
- dma_data  in  NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH  packed DMA beat
- dma_ready  out  1  beat accepted when dma_ready and dma_valid are both 1
- dac_data  out  NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH  packed output samples
- dac_data_valid  out  1  output samples are live
- dac_state  out  2  0 IDLE, 1 ARMED, 2 RUN
- dac_unf  out  1  sticky underflow flag
- dac_unf_count  out  16  saturating underflow-cycle count

Behaviour:
- Reset: all outputs and state are 0; dac_state = IDLE.
- Packing: channel c, sample s occupies bits [(c*SAMPLES_PER_CHANNEL+s)*DATA_WIDTH +: DATA_WIDTH] of both dma_data and dac_data.
- State machine:
  - IDLE -> ARMED when dac_start = 1.
  - ARMED -> RUN on dac_sync = 1 while dac_start = 1.
  - Any state -> IDLE on the cycle after dac_start = 0; dac_start has priority over dac_sync.
  - A dac_sync pulse in IDLE or RUN is ignored.
- dma_ready (combinational) = RUN AND at least one channel with dac_enable = 1 and src = 0.
- Latency: dac_data is registered exactly 1 cycle after the dma_data beat or source computation. dac_data_valid = 1 exactly in the cycles following a RUN cycle.
- In IDLE/ARMED: dac_data = 0 and dac_data_valid = 0. dac_data = 0 regardless of dac_datafmt.
- Per channel, in RUN:
  - Disabled channel: all its samples are 0. dac_datafmt is not applied to disabled channels.
  - src 0 (DMA): the dma_data slice.
  - src 1 (ramp): sample s = ramp_base + s (mod 2^DATA_WIDTH). ramp_base is a per-channel register, reset to 0 on entry to RUN, and advances by SAMPLES_PER_CHANNEL each RUN cycle with wrap-around.
  - src 2 (constant): dac_pattern in every sample.
  - src 3 (zero): 0.
- Format: if dac_datafmt = 1, the MSB of each enabled-channel sample is inverted after source selection.
- Underflow: a cycle is an underflow when dma_ready = 1 and dma_valid = 0.
  - DMA-sourced channels output the underflow value (0; see Optional Feature).
  - Non-DMA channels are unaffected.
  - dac_unf is set to 1; dac_unf_count increments and saturates at 0xFFFF.
- dac_unf_clr has priority over a simultaneous underflow: flag = 0 and count = 0 that cycle; counting resumes the next cycle.
- Returning to IDLE does not clear dac_unf or dac_unf_count.
- Reset mid-RUN: immediate return to the reset values.

Optional Feature:
- Macro: DAC_UNF_HOLD_EN.
- Defined: on underflow, DMA-sourced channels repeat their last accepted sample set (pre-format, then formatted normally). This needs a NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH hold register, cleared by reset and on entry to RUN. An underflow on the first RUN cycle outputs 0.
- Undefined: the underflow value is 0 and no hold register is built.

Test Plan:
- Reset, then dac_start = 1 with no dac_sync -> dac_state = 1, dac_data = 0, dma_ready = 0 indefinitely.
- Defaults; ch0 DMA, ch1 ramp; dac_sync; dma_data ch0 = 0x0004_0003_0002_0001, dma_valid = 1 -> one cycle later ch0 = 1,2,3,4 and ch1 = 0,1,2,3; next cycle ch1 = 4,5,6,7. Hold RUN for 16384 cycles -> ch1 ramp wraps back to 0.
- In RUN with ch0 DMA, drop dma_valid for 3 cycles -> ch0 = 0 for those 3 output cycles, dac_unf = 1, dac_unf_count = 3. Pulse dac_unf_clr concurrent with a 4th underflow -> count = 0, flag = 0.
- ch0 constant with dac_pattern = 0x1234 and dac_datafmt = 1 -> all ch0 samples = 0x9234. Disabled ch1 -> 0x0000.
- Deassert dac_start mid-RUN -> next cycle dac_state = 0, dma_ready = 0; following cycle dac_data = 0, dac_data_valid = 0. Re-arm and sync -> ramp restarts at 0.
- With DAC_UNF_HOLD_EN: last beat = 0x000A_000B_000C_000D, then dma_valid = 0 -> output repeats 0x000A_000B_000C_000D and dac_unf_count increments.

Source files
------------

// File: rtl/dac_multi_chan_datapath.sv
// Multi-channel DAC datapath: start/sync sequencing, per-channel source select, format and underflow tracking.
// Define DAC_UNF_HOLD_EN to repeat the last accepted DMA beat on underflow instead of outputting zero.
module dac_multi_chan_datapath #(
    parameter int NUM_CHANNELS        = 2,
    parameter int SAMPLES_PER_CHANNEL = 4,
    parameter int DATA_WIDTH          = 16
) (
    input  logic                                                   dac_clk,
    input  logic                                                   dac_rst,
    input  logic                                                   dac_start,
    input  logic                                                   dac_sync,
    input  logic [NUM_CHANNELS-1:0]                                dac_enable,
    input  logic [2*NUM_CHANNELS-1:0]                              dac_src_sel,
    input  logic                                                   dac_datafmt,
    input  logic [DATA_WIDTH-1:0]                                  dac_pattern,
    input  logic                                                   dac_unf_clr,
    input  logic                                                   dma_valid,
    input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] dma_data,
    output logic                                                   dma_ready,
    output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] dac_data,
    output logic                                                   dac_data_valid,
    output logic [1:0]                                             dac_state,
    output logic                                                   dac_unf,
    output logic [15:0]                                            dac_unf_count
);

    localparam int BW = NUM_CHANNELS * SAMPLES_PER_CHANNEL * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         data_q, data_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] ramp_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ramp_d [NUM_CHANNELS];
    logic                  unf_q, unf_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] dma_sel;
    logic                  run;
    logic                  unf_cycle;
    logic [BW-1:0]         unf_val;

    always_comb begin
        state_d = state_q;
        if (!dac_start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_ARMED;
                ST_ARMED: if (dac_sync) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign run = (state_q == ST_RUN);

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            dma_sel[c] = dac_enable[c] && (dac_src_sel[2*c +: 2] == 2'd0);
        end
    end

    assign dma_ready = run && (|dma_sel);
    assign unf_cycle = dma_ready && !dma_valid;

`ifdef DAC_UNF_HOLD_EN
    logic [BW-1:0] hold_q, hold_d;

    // Hold is scoped to one RUN session so a first-cycle underflow yields zero.
    always_comb begin
        hold_d = hold_q;
        if (!run) begin
            hold_d = '0;
        end else if (dma_ready && dma_valid) begin
            hold_d = dma_data;
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) hold_q <= '0;
        else         hold_q <= hold_d;
    end

    assign unf_val = hold_q;
`else
    assign unf_val = '0;
`endif

    always_comb begin
        logic [DATA_WIDTH-1:0] smp;
        data_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ramp_d[c] = run ? ramp_q[c] + DATA_WIDTH'(SAMPLES_PER_CHANNEL) : '0;
            for (int s = 0; s < SAMPLES_PER_CHANNEL; s++) begin
                smp = '0;
                case (dac_src_sel[2*c +: 2])
                    2'd0: smp = unf_cycle ? unf_val[(c*SAMPLES_PER_CHANNEL+s)*DATA_WIDTH +: DATA_WIDTH]
                                          : dma_data[(c*SAMPLES_PER_CHANNEL+s)*DATA_WIDTH +: DATA_WIDTH];
                    2'd1: smp = ramp_q[c] + DATA_WIDTH'(s);
                    2'd2: smp = dac_pattern;
                    default: smp = '0;
                endcase
                if (dac_datafmt) smp[DATA_WIDTH-1] = ~smp[DATA_WIDTH-1];
                if (run && dac_enable[c]) begin
                    data_d[(c*SAMPLES_PER_CHANNEL+s)*DATA_WIDTH +: DATA_WIDTH] = smp;
                end
            end
        end
    end

    // Clear wins over a coincident underflow; counting resumes next cycle.
    always_comb begin
        unf_d = unf_q;
        cnt_d = cnt_q;
        if (dac_unf_clr) begin
            unf_d = 1'b0;
            cnt_d = '0;
        end else if (unf_cycle) begin
            unf_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ramp_q  <= '{default: '0};
            unf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= run;
            ramp_q  <= ramp_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dac_data       = data_q;
    assign dac_data_valid = valid_q;
    assign dac_state      = state_q;
    assign dac_unf        = unf_q;
    assign dac_unf_count  = cnt_q;

endmodule
